// File: rtl/spi_request_arbiter_pkg.sv
// Shared definitions for the SPI request arbiter: FSM states, device select codes,
// operation kinds and the fixed frame layout constants.
package spi_request_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        OP_DAC_WR = 2'd0,
        OP_ADC_WR = 2'd1,
        OP_ADC_RD = 2'd2
    } arb_op_e;

    localparam logic [1:0] DEV_DAC        = 2'd0;
    localparam logic [1:0] DEV_ADC        = 2'd1;
    localparam logic [2:0] DAC_CMD_PREFIX = 3'b011;
    localparam int         ADC_RW_BIT     = 23;
    localparam int         FRAME_W        = 24;
    localparam int         TMR_W          = 16;

endpackage

// File: rtl/spi_request_arbiter_frame_builder.sv
// Combinational mapping from the granted operation to the 24-bit SPI frame.
module spi_request_arbiter_frame_builder
    import spi_request_arbiter_pkg::*;
(
    input  arb_op_e              op,
    input  logic [4:0]           dac_address,
    input  logic [11:0]          dac_data,
    input  logic [12:0]          adc_address,
    input  logic [7:0]           adc_data,
    output logic [FRAME_W-1:0]   frame
);

    always_comb begin
        frame = '0;
        case (op)
            OP_DAC_WR: frame = {DAC_CMD_PREFIX, dac_address, dac_data, 4'b0000};
            OP_ADC_WR: frame = {1'b0, 2'b00, adc_address, adc_data};
            OP_ADC_RD: begin
                // Read frames carry no payload; the master clocks the reply into the low byte.
                frame             = {1'b0, 2'b00, adc_address, 8'h00};
                frame[ADC_RW_BIT] = 1'b1;
            end
            default:   frame = '0;
        endcase
    end

endmodule

// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI master between the DAC and ADC paths.
// Optional busy-phase timeout is enabled with the SPI_ARB_TIMEOUT_EN macro.
module spi_request_arbiter
    import spi_request_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                dac_request_write,
    input  logic [4:0]          dac_address,
    input  logic [11:0]         dac_data,
    output logic                dac_ack,
    input  logic                adc_request_write,
    input  logic                adc_request_read,
    input  logic [15:0]         adc_address,
    input  logic [7:0]          adc_data,
    output logic                adc_ack,
    output logic [7:0]          adc_data_readback,
    output logic                adc_readback_valid,
    output logic                spi_busy,
    output logic                spi_start,
    output logic [1:0]          spi_dev_sel,
    output logic [FRAME_W-1:0]  spi_tx_frame,
    input  logic [7:0]          spi_rx_byte,
    input  logic                spi_master_busy,
    output logic                spi_error,
    output logic [2:0]          dbg_state
);

    // Handshake: each request level is a valid that stays high until accepted; the
    // one-cycle ack is the accept, and a request still high two cycles later is new.
    arb_state_e          state_q, state_d;
    logic [1:0]          last_grant_q, last_grant_d;
    arb_op_e             op_q, op_d, grant_op;
    logic [FRAME_W-1:0]  frame_q, frame_d, new_frame;
    logic [1:0]          dev_sel_q, dev_sel_d;
    logic                dac_ack_q, dac_ack_d;
    logic                adc_ack_q, adc_ack_d;
    logic [7:0]          rb_q, rb_d;
    logic                rb_valid_q, rb_valid_d;
    logic                dac_pend, adc_pend, grant_dac, grant_adc;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^adc_address[15:13];

    assign dac_pend  = dac_request_write;
    assign adc_pend  = adc_request_write | adc_request_read;
    assign grant_dac = dac_pend && (!adc_pend || (last_grant_q == DEV_ADC));
    assign grant_adc = adc_pend && !grant_dac;
    assign grant_op  = grant_dac ? OP_DAC_WR : (adc_request_write ? OP_ADC_WR : OP_ADC_RD);

    spi_request_arbiter_frame_builder u_frame_builder (
        .op          (grant_op),
        .dac_address (dac_address),
        .dac_data    (dac_data),
        .adc_address (adc_address[12:0]),
        .adc_data    (adc_data),
        .frame       (new_frame)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             error_q, error_d;
    logic             tmo_hit;

    assign tmo_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        frame_d      = frame_q;
        dev_sel_d    = dev_sel_q;
        dac_ack_d    = 1'b0;
        adc_ack_d    = 1'b0;
        rb_d         = rb_q;
        rb_valid_d   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        timer_d      = timer_q;
        error_d      = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_dac || grant_adc) begin
                    frame_d      = new_frame;
                    dev_sel_d    = grant_dac ? DEV_DAC : DEV_ADC;
                    last_grant_d = grant_dac ? DEV_DAC : DEV_ADC;
                    op_d         = grant_op;
                    dac_ack_d    = grant_dac;
                    adc_ack_d    = grant_adc;
                    state_d      = ST_START;
`ifdef SPI_ARB_TIMEOUT_EN
                    error_d      = 1'b0;
`endif
                end
            end
            ST_START: begin
                state_d = ST_WAIT_HI;
`ifdef SPI_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            ST_WAIT_HI: begin
                if (spi_master_busy) begin
                    state_d = ST_WAIT_LO;
`ifdef SPI_ARB_TIMEOUT_EN
                    timer_d = '0;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            ST_WAIT_LO: begin
                if (!spi_master_busy) begin
                    if (op_q == OP_ADC_RD) rb_d = spi_rx_byte;
                    state_d = ST_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                rb_valid_d = (op_q == OP_ADC_RD);
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= DEV_ADC;
            op_q         <= OP_DAC_WR;
            frame_q      <= '0;
            dev_sel_q    <= DEV_DAC;
            dac_ack_q    <= 1'b0;
            adc_ack_q    <= 1'b0;
            rb_q         <= 8'h00;
            rb_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            frame_q      <= frame_d;
            dev_sel_q    <= dev_sel_d;
            dac_ack_q    <= dac_ack_d;
            adc_ack_q    <= adc_ack_d;
            rb_q         <= rb_d;
            rb_valid_q   <= rb_valid_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end

    assign spi_error = error_q;
`else
    assign spi_error = 1'b0;
`endif

    assign spi_start          = (state_q == ST_START);
    assign spi_busy           = (state_q != ST_IDLE);
    assign spi_tx_frame       = frame_q;
    assign spi_dev_sel        = dev_sel_q;
    assign dac_ack            = dac_ack_q;
    assign adc_ack            = adc_ack_q;
    assign adc_data_readback  = rb_q;
    assign adc_readback_valid = rb_valid_q;
    assign dbg_state          = state_q;

endmodule
